// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared types and constants for the multiply/divide sequencer.
//   mdOp_t    : operation codes carried on iOp (MULT, MULTU, DIV, DIVU)
//   mdState_t : sequencer states (IDLE, PREP, RUN, FIX, DONE)
//   ALU_ADD / ALU_SUB : function codes for the shared adder/subtractor;
//                       bit 0 selects subtraction
//   opIsDiv / opIsSigned : decode helpers for an mdOp_t
// ---------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } mdState_t;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;

    function automatic logic opIsDiv(input mdOp_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic opIsSigned(input mdOp_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_seq_if.sv
// ---------------------------------------------------------------------------
// md_seq_if
// Request/result bundle between decode/EX and the multiply/divide sequencer.
//   iStart, iOp, iA, iB   : launch an operation (sampled when the unit is idle)
//   iWrHi, iWrLo, iWData  : MTHI / MTLO writes (honoured only when idle)
//   oBusy                 : unit is not idle; decode stalls on it
//   oDone                 : one-cycle completion pulse
//   oDivZero              : sticky flag, last divide had a zero divisor
//   oHi, oLo              : architectural HI / LO registers
// Modports: master = requester (decode/EX), slave = md_seq.
// ---------------------------------------------------------------------------
interface md_seq_if
    import md_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             iStart;
    mdOp_t            iOp;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iWrHi;
    logic             iWrLo;
    logic [WIDTH-1:0] iWData;
    logic             oBusy;
    logic             oDone;
    logic             oDivZero;
    logic [WIDTH-1:0] oHi;
    logic [WIDTH-1:0] oLo;

    modport master (
        output iStart, iOp, iA, iB, iWrHi, iWrLo, iWData,
        input  oBusy, oDone, oDivZero, oHi, oLo
    );

    modport slave (
        input  iStart, iOp, iA, iB, iWrHi, iWrLo, iWData,
        output oBusy, oDone, oDivZero, oHi, oLo
    );

endinterface

// File: rtl/md_addsub.sv
// ---------------------------------------------------------------------------
// md_addsub
// Combinational WIDTH-bit adder/subtractor shared by the multiply accumulate
// step and the divide trial subtraction.
//   iX, iY : operands
//   iSub   : 0 -> oS = iX + iY, 1 -> oS = iX - iY (modulo 2^WIDTH)
//   oS     : result
// ---------------------------------------------------------------------------
module md_addsub #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] iX,
    input  logic [WIDTH-1:0] iY,
    input  logic             iSub,
    output logic [WIDTH-1:0] oS
);

    assign oS = iSub ? (iX - iY) : (iX + iY);

endmodule

// File: rtl/md_seq.sv
// ---------------------------------------------------------------------------
// md_seq
// Multi-cycle multiply/divide sequencer holding the architectural HI/LO pair.
// MULT/MULTU use a WIDTH-step shift-add loop, DIV/DIVU a WIDTH-step restoring
// divide; signed operations run on magnitudes and fix the sign at the end.
//   iClk : clock, all state changes on the rising edge
//   iRst : synchronous active-high reset; abandons any operation in flight
//   bus  : md_seq_if.slave -- start/operands, MTHI/MTLO, busy/done/HI/LO
// Sequence: IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> DONE -> IDLE.
// A zero divisor short-cuts PREP -> DONE with HI=dividend, LO=all-ones.
// ---------------------------------------------------------------------------
module md_seq
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     iClk,
    input logic     iRst,
    md_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    // FSM
    mdState_t state;
    mdState_t stateNext;
    logic     busy;
    logic     done;

    // Architectural / control state (reset)
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             divZero;
    logic [CW-1:0]    cnt;

    // Operation scratch state (not reset)
    mdOp_t            opReg;
    logic [WIDTH-1:0] aReg;     // raw A, then |A| (multiplicand)
    logic [WIDTH-1:0] bReg;     // raw B, then |B| (divisor)
    logic [WIDTH:0]   accReg;   // mult: partial-product high half; div: remainder
    logic [WIDTH-1:0] shReg;    // mult: multiplier / product low; div: quotient
    logic             negQuo;   // product or quotient must be negated
    logic             negRem;   // remainder must be negated

    // Datapath
    logic             isDiv;
    logic             isSigned;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic             divByZero;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   addX;
    logic [WIDTH:0]   addY;
    logic [WIDTH:0]   addS;
    logic             addSub;
    logic [WIDTH:0]   accNext;
    logic [WIDTH-1:0] shNext;
    logic [2*WIDTH-1:0] prodRaw;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;

    // ------------------------------------------------------------------
    // Operand preparation (valid in PREP while aReg/bReg hold raw inputs)
    // ------------------------------------------------------------------
    assign isDiv     = opIsDiv(opReg);
    assign isSigned  = opIsSigned(opReg);
    assign aNeg      = isSigned & aReg[WIDTH-1];
    assign bNeg      = isSigned & bReg[WIDTH-1];
    assign aMag      = aNeg ? -aReg : aReg;
    assign bMag      = bNeg ? -bReg : bReg;
    assign divByZero = isDiv && (bReg == '0);

    // ------------------------------------------------------------------
    // One iteration. Multiply adds the multiplicand when the current
    // multiplier bit is set; divide subtracts the divisor from the
    // left-shifted remainder and keeps the result only if it is not negative.
    // ------------------------------------------------------------------
    assign divShift = {accReg[WIDTH-1:0], shReg[WIDTH-1]};
    assign addX     = isDiv ? divShift : accReg;
    assign addY     = {1'b0, isDiv ? bReg : (shReg[0] ? aReg : '0)};
    assign addSub   = isDiv ? ALU_SUB[0] : ALU_ADD[0];

    md_addsub #(
        .WIDTH (WIDTH + 1)
    ) uAddSub (
        .iX   (addX),
        .iY   (addY),
        .iSub (addSub),
        .oS   (addS)
    );

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        accNext = {1'b0, addS[WIDTH:1]};
        shNext  = {addS[0], shReg[WIDTH-1:1]};
        if (isDiv) begin
            if (addS[WIDTH]) begin
                // Trial went negative: restore the shifted remainder.
                accNext = divShift;
                shNext  = {shReg[WIDTH-2:0], 1'b0};
            end else begin
                accNext = addS;
                shNext  = {shReg[WIDTH-2:0], 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up of the magnitude results
    // ------------------------------------------------------------------
    assign prodRaw = {accReg[WIDTH-1:0], shReg};
    assign prodFix = negQuo ? -prodRaw : prodRaw;
    assign quoFix  = negQuo ? -shReg : shReg;
    assign remFix  = negRem ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.iStart) begin
                    stateNext = PREP;
                end
            end
            PREP: begin
                stateNext = divByZero ? DONE : RUN;
            end
            RUN: begin
                if (cnt == '0) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Architectural HI/LO, sticky divide-by-zero flag, iteration counter.
    // HI/LO change only by MTHI/MTLO in IDLE or by the final FIX / zero
    // divisor write, so oHi/oLo never expose partial results.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            hiReg   <= '0;
            loReg   <= '0;
            divZero <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        divZero <= 1'b0;
                    end else begin
                        if (bus.iWrHi) hiReg <= bus.iWData;
                        if (bus.iWrLo) loReg <= bus.iWData;
                    end
                end
                PREP: begin
                    cnt <= CW'(WIDTH - 1);
                    if (divByZero) begin
                        hiReg   <= aReg;
                        loReg   <= '1;
                        divZero <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (isDiv) begin
                        hiReg <= remFix;
                        loReg <= quoFix;
                    end else begin
                        hiReg <= prodFix[2*WIDTH-1:WIDTH];
                        loReg <= prodFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operation scratch registers.
    // NOTE: these are always loaded before use (accept in IDLE, then PREP),
    // so they carry no reset; only state visible outside is reset.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    opReg <= bus.iOp;
                    aReg  <= bus.iA;
                    bReg  <= bus.iB;
                end
            end
            PREP: begin
                aReg   <= aMag;
                bReg   <= bMag;
                negQuo <= aNeg ^ bNeg;
                negRem <= aNeg;
                accReg <= '0;
                shReg  <= isDiv ? aMag : bMag;
            end
            RUN: begin
                accReg <= accNext;
                shReg  <= shNext;
            end
            default: ;
        endcase
    end

    assign bus.oBusy    = busy;
    assign bus.oDone    = done;
    assign bus.oDivZero = divZero;
    assign bus.oHi      = hiReg;
    assign bus.oLo      = loReg;

endmodule

// File: tb/tb_md_seq.sv
// ---------------------------------------------------------------------------
// tb_md_seq
// Self-checking bench for md_seq: directed corner cases plus randomized
// MULT/MULTU/DIV/DIVU and MTHI/MTLO traffic, compared against a reference
// model built on plain 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_md_seq;
    import md_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    md_seq_if #(.WIDTH(WIDTH)) bus ();

    md_seq #(.WIDTH(WIDTH)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;

    typedef struct {
        mdOp_t       op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t directed[6];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: MIPS semantics from integer arithmetic.
    task automatic refModel(input mdOp_t op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo,
                            output logic dz, output int lat);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        dz  = 1'b0;
        lat = 34;
        case (op)
            MD_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            MD_MULT: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi  = a;
                    lo  = 32'hFFFF_FFFF;
                    dz  = 1'b1;
                    lat = 1;
                end else if (op == MD_DIV) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hi = r[31:0];
                    lo = q[31:0];
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
        endcase
    endtask

    // Launch one operation and follow it to completion.
    //   pokeAt : edge count after accept at which a stray iStart is raised
    //   rstAt  : edge count after accept at which iRst is raised (abandon)
    //   wrHiToo: raise iWrHi together with iStart
    task automatic runOp(input mdOp_t op, input logic [31:0] a, input logic [31:0] b,
                         input int pokeAt, input int rstAt, input bit wrHiToo);
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          edges;
        bit          sawDone;
        refModel(op, a, b, hi, lo, dz, lat);
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iOp    = op;
        bus.iA     = a;
        bus.iB     = b;
        if (wrHiToo) begin
            bus.iWrHi  = 1'b1;
            bus.iWData = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        bus.iWrHi  = 1'b0;
        bus.iA     = $urandom;
        bus.iB     = $urandom;
        edges      = 0;
        while (!bus.oDone && edges < 100) begin
            check("busyWhileRunning", bus.oBusy, 1'b1);
            check("hiHold", bus.oHi, expHi);
            check("loHold", bus.oLo, expLo);
            if (edges == 0) check("divZeroClearedOnAccept", bus.oDivZero, 1'b0);
            if (rstAt != 0 && edges == rstAt) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check("rstBusy", bus.oBusy, 1'b0);
                check("rstDone", bus.oDone, 1'b0);
                check("rstHi", bus.oHi, 32'd0);
                check("rstLo", bus.oLo, 32'd0);
                check("rstDivZero", bus.oDivZero, 1'b0);
                expHi   = '0;
                expLo   = '0;
                expDz   = 1'b0;
                sawDone = 1'b0;
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    if (bus.oDone) sawDone = 1'b1;
                end
                check("noDoneAfterRst", sawDone, 1'b0);
                return;
            end
            if (pokeAt != 0 && edges == pokeAt) begin
                bus.iStart = 1'b1;
                bus.iOp    = MD_MULTU;
                bus.iA     = $urandom;
                bus.iB     = $urandom;
            end else if (pokeAt != 0 && edges == pokeAt + 1) begin
                bus.iStart = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", edges, lat);
        check("hi", bus.oHi, hi);
        check("lo", bus.oLo, lo);
        check("divZero", bus.oDivZero, dz);
        check("busyInDone", bus.oBusy, 1'b1);
        expHi = hi;
        expLo = lo;
        expDz = dz;
        @(posedge clk);
        #1;
        check("donePulseOnly", bus.oDone, 1'b0);
        check("idleAfterDone", bus.oBusy, 1'b0);
    endtask

    task automatic writeHiLo(input logic wrHi, input logic wrLo, input logic [31:0] data);
        @(negedge clk);
        bus.iWrHi  = wrHi;
        bus.iWrLo  = wrLo;
        bus.iWData = data;
        @(posedge clk);
        #1;
        bus.iWrHi = 1'b0;
        bus.iWrLo = 1'b0;
        if (wrHi) expHi = data;
        if (wrLo) expLo = data;
        check("mtHi", bus.oHi, expHi);
        check("mtLo", bus.oLo, expLo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        directed[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        directed[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        directed[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        directed[3] = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        directed[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        directed[5] = '{MD_DIV,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};

        rst        = 1'b1;
        bus.iStart = 1'b0;
        bus.iOp    = MD_MULT;
        bus.iA     = '0;
        bus.iB     = '0;
        bus.iWrHi  = 1'b0;
        bus.iWrLo  = 1'b0;
        bus.iWData = '0;
        expHi      = '0;
        expLo      = '0;
        expDz      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("resetBusy", bus.oBusy, 1'b0);
        check("resetDone", bus.oDone, 1'b0);
        check("resetDivZero", bus.oDivZero, 1'b0);
        check("resetHi", bus.oHi, 32'd0);
        check("resetLo", bus.oLo, 32'd0);
        rst = 1'b0;

        // Known-answer cases; consecutive calls start in the first IDLE cycle.
        foreach (directed[i]) begin
            runOp(directed[i].op, directed[i].a, directed[i].b, 0, 0, 1'b0);
            check($sformatf("knownHi%0d", i), bus.oHi, directed[i].hi);
            check($sformatf("knownLo%0d", i), bus.oLo, directed[i].lo);
        end
        check("divZeroSticky", bus.oDivZero, 1'b1);

        // MTHI / MTLO in IDLE
        writeHiLo(1'b1, 1'b1, 32'h1234_5678);
        writeHiLo(1'b1, 1'b0, 32'hCAFE_F00D);
        writeHiLo(1'b0, 1'b1, 32'h0BAD_1DEA);

        // Stray iStart during RUN is ignored
        runOp(MD_MULTU, 32'd3, 32'd5, 6, 0, 1'b0);
        // MTHI together with iStart is dropped
        runOp(MD_DIVU, 32'd100, 32'd9, 0, 0, 1'b1);
        // Reset in the middle of RUN abandons the operation
        runOp(MD_DIV, 32'd12345, 32'd77, 0, 11, 1'b0);
        // Sticky flag set then cleared by the next accepted start
        runOp(MD_DIVU, 32'd9, 32'd0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("divZeroHeldIdle", bus.oDivZero, 1'b1);
        runOp(MD_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                writeHiLo(1'($urandom), 1'($urandom), $urandom);
            end
            runOp(mdOp_t'($urandom_range(0, 3)), pick(), pick(), 0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
